// File: rtl/aes_inv_round_core.sv
// One AES decryption round without InvSubBytes: InvShiftRows(InvMixColumns(block ^ key)).
// Build option AES_INV_ROUND_PARALLEL_EN mixes all four columns in one cycle instead of one per cycle.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_inv_round_core (
   input  logic                       Clk,
   input  logic                       Rst_n,
   input  logic                       In_valid,
   output logic                       In_ready,
   input  logic [`AES_BLOCK_SIZE-1:0] In_block,
   input  logic [`AES_BLOCK_SIZE-1:0] In_key,
   input  logic                       Mix_en,
   output logic                       Out_valid,
   input  logic                       Out_ready,
   output logic [`AES_BLOCK_SIZE-1:0] Out_block
);

   localparam int BW = `AES_BLOCK_SIZE;

   typedef enum logic [1:0] {IDLE, MIX, OUT} state_t;

   state_t          state_q, state_d;
   logic            ready_en_q;
   logic            accept;
   logic            mix_last;
   logic [BW-1:0]   buf_q;
   logic [BW-1:0]   buf_mixed;
   logic [BW-1:0]   out_q;
   logic [BW-1:0]   key_added;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m09 [4];
      logic [7:0] m0b [4];
      logic [7:0] m0d [4];
      logic [7:0] m0e [4];
      logic [31:0] res;
      for (int r = 0; r < 4; r++) begin
         a[r]   = col[8*r +: 8];
         x2[r]  = xt(a[r]);
         x4[r]  = xt(x2[r]);
         x8[r]  = xt(x4[r]);
         m09[r] = x8[r] ^ a[r];
         m0b[r] = x8[r] ^ x2[r] ^ a[r];
         m0d[r] = x8[r] ^ x4[r] ^ a[r];
         m0e[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      res[7:0]   = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
      res[15:8]  = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
      res[23:16] = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
      res[31:24] = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
      return res;
   endfunction

   // Row r rotates right by r columns: out byte 4c+r takes in byte 4((c-r) mod 4)+r.
   function automatic logic [BW-1:0] inv_shift_rows(input logic [BW-1:0] s);
      logic [BW-1:0] res;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
         end
      end
      return res;
   endfunction

   assign key_added = In_block ^ In_key;
   assign In_ready  = ready_en_q && (state_q == IDLE);
   assign Out_valid = (state_q == OUT);
   assign Out_block = out_q;

`ifdef AES_INV_ROUND_PARALLEL_EN
   assign mix_last = 1'b1;

   always_comb begin
      buf_mixed = buf_q;
      for (int c = 0; c < 4; c++) begin
         buf_mixed[32*c +: 32] = inv_mix_col(buf_q[32*c +: 32]);
      end
   end
`else
   logic [1:0] col_q;

   assign mix_last = (col_q == 2'd3);

   always_comb begin
      buf_mixed = buf_q;
      buf_mixed[{col_q, 5'd0} +: 32] = inv_mix_col(buf_q[{col_q, 5'd0} +: 32]);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         col_q <= 2'd0;
      end else if (accept) begin
         col_q <= 2'd0;
      end else if (state_q == MIX) begin
         col_q <= col_q + 2'd1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (In_valid && ready_en_q) begin
               accept  = 1'b1;
               state_d = Mix_en ? MIX : OUT;
            end
         end
         MIX:     if (mix_last) state_d = OUT;
         OUT:     if (Out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q    <= IDLE;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ready_en_q <= 1'b1;
      end
   end

   // Result register loads on a bypass acceptance or on the last mix step; otherwise holds.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         buf_q <= '0;
         out_q <= '0;
      end else if (accept) begin
         buf_q <= key_added;
         if (!Mix_en) out_q <= inv_shift_rows(key_added);
      end else if (state_q == MIX) begin
         buf_q <= buf_mixed;
         if (mix_last) out_q <= inv_shift_rows(buf_mixed);
      end
   end

endmodule
